// File: rtl/mips_dump_pkg.sv
// mips_dump_pkg: shared FSM encoding and default memory sizing for the dump reader
package mips_dump_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/dump_csum_acc.sv
// dump_csum_acc: modulo-2^DATA_W running sum of accepted dump words
//   clk1/rst_n : clock, synchronous active-low reset
//   clr        : zero the sum (start of a dump)
//   add        : accumulate din this cycle
//   din / sum  : word in, running sum out
module dump_csum_acc #(
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);
  always_ff @(posedge clk1)
    if (!rst_n || clr) sum <= '0;
    else if (add) sum <= sum + din;
endmodule

// File: rtl/mips_mem_dump_reader.sv
// mips_mem_dump_reader: after HALTED, streams data memory [BASE..BASE+COUNT-1] out as addr/data/last beats
//   clk1, rst_n            : clock, synchronous active-low reset
//   halted                 : pipeline halt flag, starts a dump
//   mem_rd_en/addr/data    : synchronous read port, data valid one cycle after en
//   out_valid/ready/data/addr/last : output stream
//   busy, done             : status
//   DUMP_CHECKSUM_EN       : when defined, appends a sum beat (addr 0, last=1)
module mips_mem_dump_reader
  import mips_dump_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BASE   = 0,
  parameter int COUNT  = 16
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE + COUNT - 1);
  state_t state, nxt;
  logic [ADDR_W-1:0] cnt, addr_q;
  logic [DATA_W-1:0] data_q;
  logic last_q;
  logic send_fire;
  assign send_fire = state == SEND && out_ready;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  dump_csum_acc #(.DATA_W(DATA_W)) u_acc (
    .clk1(clk1),
    .rst_n(rst_n),
    .clr(state == IDLE && halted),
    .add(send_fire),
    .din(data_q),
    .sum(sum)
  );
  localparam state_t AFTER_LAST = CSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif
  always_ff @(posedge clk1)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = halted ? READ : IDLE;
      READ:    nxt = CAPT;
      CAPT:    nxt = SEND;
      SEND:    nxt = out_ready ? (last_q ? AFTER_LAST : READ) : SEND;
      CSUM:    nxt = out_ready ? DONE : CSUM;
      DONE:    nxt = halted ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk1)
    if (!rst_n) begin
      cnt    <= FIRST;
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == IDLE && halted) cnt <= FIRST;
      if (state == CAPT) begin
        data_q <= mem_rd_data;
        addr_q <= cnt;
        last_q <= cnt == LAST;
      end
      if (send_fire && !last_q) cnt <= cnt + ADDR_W'(1);
    end
  always_comb begin
    mem_rd_en   = state == READ;
    mem_rd_addr = state == READ ? cnt : '0;
    out_valid   = state == SEND || state == CSUM;
    busy        = state != IDLE && state != DONE;
    done        = state == DONE;
`ifdef DUMP_CHECKSUM_EN
    out_data    = state == CSUM ? sum : data_q;
    out_addr    = state == CSUM ? '0 : addr_q;
    out_last    = state == CSUM;
`else
    out_data    = data_q;
    out_addr    = addr_q;
    out_last    = last_q;
`endif
  end
endmodule

// File: tb/tb_mips_mem_dump_reader.sv
// tb_mips_mem_dump_reader: directed self-checking bench for the dump reader
module tb_mips_mem_dump_reader;
  logic clk1 = 1'b0;
  logic rst_n, halted, halted1, out_ready;
  logic mem_rd_en, mem_rd_en1;
  logic [3:0] mem_rd_addr, mem_rd_addr1, out_addr, out_addr1;
  logic [31:0] mem_rd_data, mem_rd_data1, out_data, out_data1;
  logic out_valid, out_valid1, out_last, out_last1, busy, busy1, done, done1;
  logic [31:0] mem [16];
  int rd_cnt = 0;
  int errors = 0;
  int checks = 0;
  int r0;
  always #5 clk1 = ~clk1;
  mips_mem_dump_reader #(.ADDR_W(4), .DATA_W(32), .BASE(1), .COUNT(4)) dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );
  mips_mem_dump_reader #(.ADDR_W(4), .DATA_W(32), .BASE(9), .COUNT(1)) dut1 (
    .clk1(clk1), .rst_n(rst_n), .halted(halted1),
    .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_data(out_data1),
    .out_addr(out_addr1), .out_last(out_last1), .busy(busy1), .done(done1)
  );
  always @(posedge clk1) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_rd_en1) mem_rd_data1 <= mem[mem_rd_addr1];
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
  end
  task automatic step;
    @(posedge clk1);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input string tag);
    for (int n = 0; n < 20 && !out_valid; n++) step();
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
  endtask
  task automatic beat(input string tag, input logic [3:0] a, input logic [31:0] d, input logic l);
    wait_valid(tag);
    chk({tag, ".addr"}, 32'(out_addr), 32'(a));
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".last"}, 32'(out_last), 32'(l));
    step();
  endtask
  task automatic dump4(input string tag);
`ifdef DUMP_CHECKSUM_EN
    beat({tag, ".b1"}, 4'd1, 32'd7, 1'b0);
    beat({tag, ".b2"}, 4'd2, 32'd1, 1'b0);
    beat({tag, ".b3"}, 4'd3, 32'd2, 1'b0);
    beat({tag, ".b4"}, 4'd4, 32'd12, 1'b0);
    beat({tag, ".csum"}, 4'd0, 32'd22, 1'b1);
`else
    beat({tag, ".b1"}, 4'd1, 32'd7, 1'b0);
    beat({tag, ".b2"}, 4'd2, 32'd1, 1'b0);
    beat({tag, ".b3"}, 4'd3, 32'd2, 1'b0);
    beat({tag, ".b4"}, 4'd4, 32'd12, 1'b1);
`endif
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'(i * 100 + 5);
    mem[1] = 32'd7; mem[2] = 32'd1; mem[3] = 32'd2; mem[4] = 32'd12; mem[9] = 32'd4;
    rst_n = 1'b0; halted = 1'b0; halted1 = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst.rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst.data", out_data, 32'd0);
    rst_n = 1'b1;
    step();
    halted = 1'b1;
    r0 = rd_cnt;
    step();
    chk("lat.rd_en", 32'(mem_rd_en), 32'd1);
    chk("lat.rd_addr", 32'(mem_rd_addr), 32'd1);
    chk("lat.busy", 32'(busy), 32'd1);
    step();
    chk("lat.capt_valid", 32'(out_valid), 32'd0);
    chk("lat.capt_rd_en", 32'(mem_rd_en), 32'd0);
    step();
    chk("lat.send_valid", 32'(out_valid), 32'd1);
    dump4("s1");
    chk("s1.done", 32'(done), 32'd1);
    chk("s1.valid_off", 32'(out_valid), 32'd0);
    chk("s1.busy_off", 32'(busy), 32'd0);
    chk("s1.rd_pulses", 32'(rd_cnt - r0), 32'd4);
    repeat (5) step();
    chk("hold.no_redump", 32'(rd_cnt - r0), 32'd4);
    chk("hold.done", 32'(done), 32'd1);
    halted = 1'b0;
    step();
    chk("rearm.done_clr", 32'(done), 32'd0);
    halted = 1'b1;
    r0 = rd_cnt;
    step();
    chk("rearm.rd_en", 32'(mem_rd_en), 32'd1);
    beat("bp.b1", 4'd1, 32'd7, 1'b0);
    wait_valid("bp.b2");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.stall_valid", 32'(out_valid), 32'd1);
      chk("bp.stall_data", out_data, 32'd1);
      chk("bp.stall_addr", 32'(out_addr), 32'd2);
    end
    chk("bp.stall_rd_pulses", 32'(rd_cnt - r0), 32'd2);
    out_ready = 1'b1;
`ifdef DUMP_CHECKSUM_EN
    beat("bp.b2", 4'd2, 32'd1, 1'b0);
    beat("bp.b3", 4'd3, 32'd2, 1'b0);
    beat("bp.b4", 4'd4, 32'd12, 1'b0);
    beat("bp.csum", 4'd0, 32'd22, 1'b1);
`else
    beat("bp.b2", 4'd2, 32'd1, 1'b0);
    beat("bp.b3", 4'd3, 32'd2, 1'b0);
    beat("bp.b4", 4'd4, 32'd12, 1'b1);
`endif
    chk("bp.done", 32'(done), 32'd1);
    chk("bp.rd_pulses", 32'(rd_cnt - r0), 32'd4);
    halted = 1'b0;
    step();
    halted = 1'b1;
    step();
    beat("mid.b1", 4'd1, 32'd7, 1'b0);
    beat("mid.b2", 4'd2, 32'd1, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid.rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.data", out_data, 32'd0);
    chk("mid.addr", 32'(out_addr), 32'd0);
    chk("mid.last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    r0 = rd_cnt;
    step();
    chk("restart.rd_addr", 32'(mem_rd_addr), 32'd1);
    dump4("restart");
    chk("restart.done", 32'(done), 32'd1);
    chk("restart.rd_pulses", 32'(rd_cnt - r0), 32'd4);
    halted1 = 1'b1;
    for (int n = 0; n < 20 && !out_valid1; n++) step();
    chk("c1.valid", 32'(out_valid1), 32'd1);
    chk("c1.addr", 32'(out_addr1), 32'd9);
    chk("c1.data", out_data1, 32'd4);
`ifdef DUMP_CHECKSUM_EN
    chk("c1.last", 32'(out_last1), 32'd0);
    step();
    chk("c1.csum_addr", 32'(out_addr1), 32'd0);
    chk("c1.csum_data", out_data1, 32'd4);
    chk("c1.csum_last", 32'(out_last1), 32'd1);
`else
    chk("c1.last", 32'(out_last1), 32'd1);
`endif
    step();
    chk("c1.done", 32'(done1), 32'd1);
    chk("c1.valid_off", 32'(out_valid1), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mips_mem_dump_reader.md
Name: mips_mem_dump_reader

Overview:
- Read-out counterpart to the program/data preload path of mips_pipeline: once the core raises HALTED, this block walks a contiguous window of data memory through a synchronous read port.
- Each word is emitted on a valid/ready stream, together with its address and a last flag.
- Sits beside mips_pipeline in the top-level harness and feeds result checkers, or a UART/log sink, without hierarchical peeking.

Parameters:
- ADDR_W, 4, data-memory address width (words).
- DATA_W, 32, memory word width.
- BASE, 0, first word address dumped.
- COUNT, 16, number of words dumped (1..2^ADDR_W; BASE+COUNT-1 must not exceed 2^ADDR_W-1).

Ports:
- clk1  in  1  sole clock; the pipeline's phase-1 clock.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk1.
- halted  in  1  HALTED flag from the pipeline.
- mem_rd_en  out  1  read strobe to data memory.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_W  dumped word.
- out_addr  out  ADDR_W  address of out_data.
- out_last  out  1  final beat of the dump.
- busy  out  1  dump in progress (any state except IDLE and DONE).
- done  out  1  dump completed; stays high until halted falls.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0; address counter=BASE. Applies mid-dump too: the dump is abandoned and the partial stream is not resumed.
- States: IDLE, READ, CAPT, SEND, DONE.
  - IDLE: if halted=1, go to READ; the address counter loads BASE.
  - READ: mem_rd_en=1 and mem_rd_addr=counter for exactly this cycle; go to CAPT.
  - CAPT: register mem_rd_data into out_data and the counter into out_addr. out_last=(counter==BASE+COUNT-1). Go to SEND.
  - SEND: out_valid=1. out_data, out_addr and out_last are held stable while out_ready=0 (no drop, no change).
  - On an edge with out_valid&out_ready: if out_last, go to DONE; else counter+1, go to READ.
  - DONE: done=1, out_valid=0. When halted=0, go to IDLE; a later halt triggers a fresh dump.
- Latency: halted seen high in IDLE at edge N gives mem_rd_en high in cycle N+1 and out_valid high from cycle N+3. Minimum 3 cycles per word with out_ready tied high.
- halted falling mid-dump: ignored; the dump runs to completion, then DONE exits on the next cycle since halted=0.
- COUNT=1: a single beat with out_last=1.
- Data is passed bit-exact, including X/Z from uninitialised memory. No arithmetic on data in the base configuration.
- The counter never wraps: the parameter check guarantees the window fits, so the BASE+COUNT-1 compare is exact.
- mem_rd_en is never asserted outside READ.

Optional Feature:
- DUMP_CHECKSUM_EN.
- When defined: a DATA_W-bit running sum (modulo 2^DATA_W) accumulates each accepted word.
  - After the last memory word, one extra beat is emitted: out_data=sum, out_addr=0.
  - out_last moves to this checksum beat; the memory beats all have out_last=0.
  - State CSUM is inserted between the final SEND handshake and DONE.
  - The sum clears on reset and on leaving IDLE.
  - An X word makes the sum X; this is accepted behaviour.
- When undefined: no accumulator, no extra beat, no CSUM state.

Decomposition:
- Shared package mips_dump_pkg holds:
  - the state enum (IDLE, READ, CAPT, SEND, CSUM, DONE) with fixed encoding 3'd0..3'd5;
  - default ADDR_W/DATA_W constants shared with mips_pipeline memory sizing.
- One natural sub-module: dump_csum_acc (clear, add-enable, data in, sum out), instantiated only under DUMP_CHECKSUM_EN.
- The FSM and counter stay in the top.

Test Plan:
- Setup: BASE=1, COUNT=4, memory[1..4]=7,1,2,12, out_ready=1, halt raised → beats (addr,data)=(1,7),(2,1),(3,2),(4,12); out_last only on addr 4; done high after; exactly 4 mem_rd_en pulses.
- Backpressure: out_ready low for 5 cycles during beat 2 → out_data=1/out_addr=2 held stable all 5 cycles; no extra mem_rd_en; sequence unchanged.
- Reset mid-dump: rst_n=0 one edge after beat 2 accepted → next cycle all outputs 0, state IDLE. With halted still 1, the dump restarts from addr 1.
- Re-arm: done=1, drop halted for 1 cycle, raise again → done clears, a second identical 4-beat dump occurs. Holding halted high without dropping produces no second dump.
- COUNT=1, BASE=9, memory[9]=4 → single beat (9,4) with out_last=1, then DONE.
- DUMP_CHECKSUM_EN defined, first scenario → 5 beats; fifth beat data=22 (7+1+2+12), addr=0, out_last=1; the four memory beats have out_last=0.
